datapath: RTL and testbench

Register-and-bus datapath of the 8-bit computer; directly downstream of the microcode controller. Consumes the controller's 12-bit control word each cycle and moves data between the program counter, memory address register, 16x8 RAM, instruction register, A and B registers and the adder over a shared 8-bit bus. Returns the current opcode (IR high nibble) to the controller, and exposes A, the bus and status for observation.

---
 rtl/datapath_pkg.sv | 32 +++
 rtl/datapath_ram_16x8.sv | 27 ++
 rtl/datapath.sv | 117 +++++++++++
 tb/tb_datapath.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the 8-bit computer: control-word bit positions, opcodes
// and default widths. Imported by the datapath and the microcode controller.
package datapath_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 4;
    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned CTRL_W         = 12;
    localparam int unsigned OPCODE_W       = 4;
    localparam int unsigned OPERAND_W      = 4;

    // Control-word bit indices
    localparam int HLT       = 11;
    localparam int PC_INC    = 10;
    localparam int PC_EN     = 9;
    localparam int MAR_LOAD  = 8;
    localparam int MEM_EN    = 7;
    localparam int IR_LOAD   = 6;
    localparam int IR_EN     = 5;
    localparam int A_LOAD    = 4;
    localparam int A_EN      = 3;
    localparam int B_LOAD    = 2;
    localparam int ADDER_SUB = 1;
    localparam int ADDER_EN  = 0;

    typedef enum logic [OPCODE_W-1:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_HLT = 4'hF
    } opcode_e;

endpackage

// File: rtl/datapath_ram_16x8.sv
// Program/data RAM: synchronous write port (program load), asynchronous read
// port (drives the bus through the datapath mux). Contents are never reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module ram_16x8 #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero-latency read: a same-edge write is seen only after the edge.
    assign rdata = mem[raddr];

endmodule

// File: rtl/datapath.sv
// Register-and-bus datapath of the 8-bit computer. Executes one 12-bit control
// word per cycle, moving data over a shared bus between PC, MAR, RAM, IR, A, B
// and the adder.
// Ports: clk, rst (async, active high), ctrl (control word), prog_we/prog_addr/
// prog_data (RAM program load), opcode (IR high nibble to controller), bus,
// a_out, carry, zero, halted (observation), bus_conflict (multiple drivers).
module datapath
    import datapath_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CTRL_W-1:0]   ctrl,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [DATA_W-1:0]   prog_data,
    output logic [OPCODE_W-1:0] opcode,
    output logic [DATA_W-1:0]   bus,
    output logic [DATA_W-1:0]   a_out,
    output logic                carry,
    output logic                zero,
    output logic                halted,
    output logic                bus_conflict
);

    logic [ADDR_W-1:0] pc_q, mar_q;
    logic [DATA_W-1:0] ir_q, a_q, b_q;
    logic              carry_q, zero_q, halted_q;

    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] b_operand;
    logic [DATA_W:0]   sum_ext;
    logic [4:0]        drivers;

    ram_16x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (mar_q),
        .rdata (ram_rdata)
    );

    // Subtract is A + ~B + 1, so carry out = 1 means no borrow.
    always_comb begin
        b_operand = ctrl[ADDER_SUB] ? ~b_q : b_q;
        sum_ext   = {1'b0, a_q} + {1'b0, b_operand} + {{DATA_W{1'b0}}, ctrl[ADDER_SUB]};
    end

    assign drivers      = {ctrl[MEM_EN], ctrl[ADDER_EN], ctrl[A_EN], ctrl[IR_EN], ctrl[PC_EN]};
    assign bus_conflict = ($countones(drivers) > 1);

    // Fixed-priority mux keeps the bus defined even when drivers collide.
    always_comb begin
        bus = '0;
        if (ctrl[MEM_EN]) begin
            bus = ram_rdata;
        end else if (ctrl[ADDER_EN]) begin
            bus = sum_ext[DATA_W-1:0];
        end else if (ctrl[A_EN]) begin
            bus = a_q;
        end else if (ctrl[IR_EN]) begin
            bus = {{(DATA_W-OPERAND_W){1'b0}}, ir_q[OPERAND_W-1:0]};
        end else if (ctrl[PC_EN]) begin
            bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
        end
    end

    // Halt freezes state by gating enables; the clock keeps running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            mar_q    <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            if (ctrl[PC_INC]) begin
                pc_q <= pc_q + 1'b1;
            end
            if (ctrl[MAR_LOAD]) begin
                mar_q <= bus[ADDR_W-1:0];
            end
            if (ctrl[IR_LOAD]) begin
                ir_q <= bus;
            end
            if (ctrl[A_LOAD]) begin
                a_q <= bus;
            end
            if (ctrl[B_LOAD]) begin
                b_q <= bus;
            end
            if (ctrl[A_LOAD] && ctrl[ADDER_EN]) begin
                carry_q <= sum_ext[DATA_W];
                zero_q  <= (sum_ext[DATA_W-1:0] == '0);
            end
            if (ctrl[HLT]) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign opcode = ir_q[DATA_W-1 -: OPCODE_W];
    assign a_out  = a_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

    localparam logic [11:0] C_HLT    = 12'h800;
    localparam logic [11:0] C_PC_INC = 12'h400;
    localparam logic [11:0] C_PC_EN  = 12'h200;
    localparam logic [11:0] C_MAR_LD = 12'h100;
    localparam logic [11:0] C_MEM_EN = 12'h080;
    localparam logic [11:0] C_IR_LD  = 12'h040;
    localparam logic [11:0] C_IR_EN  = 12'h020;
    localparam logic [11:0] C_A_LD   = 12'h010;
    localparam logic [11:0] C_A_EN   = 12'h008;
    localparam logic [11:0] C_B_LD   = 12'h004;
    localparam logic [11:0] C_SUB    = 12'h002;
    localparam logic [11:0] C_ADD_EN = 12'h001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] ctrl = '0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [7:0]  prog_data = '0;
    logic [3:0]  opcode;
    logic [7:0]  bus;
    logic [7:0]  a_out;
    logic        carry, zero, halted, bus_conflict;

    int checks = 0;
    int errors = 0;

    datapath dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl         (ctrl),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .opcode       (opcode),
        .bus          (bus),
        .a_out        (a_out),
        .carry        (carry),
        .zero         (zero),
        .halted       (halted),
        .bus_conflict (bus_conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [11:0] c);
        @(negedge clk);
        ctrl = c;
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        ctrl      = '0;
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        ctrl = '0;
        rst  = 1'b1;
        #2;
        rst  = 1'b0;
    endtask

    // Behavioural microcode controller: six stages per instruction.
    function automatic logic [11:0] ctrl_word(input int stage, input logic [3:0] op);
        case (stage)
            0: return C_PC_EN | C_MAR_LD;
            1: return C_PC_INC | C_MEM_EN | C_IR_LD;
            2: return (op == 4'hF) ? C_HLT : (C_IR_EN | C_MAR_LD);
            3: return (op == 4'h0) ? (C_MEM_EN | C_A_LD) :
                      (op == 4'h1 || op == 4'h2) ? (C_MEM_EN | C_B_LD) : 12'h000;
            4: return (op == 4'h1) ? (C_ADD_EN | C_A_LD) :
                      (op == 4'h2) ? (C_ADD_EN | C_SUB | C_A_LD) : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    task automatic run_cycles(input int n);
        for (int cyc = 1; cyc <= n; cyc++) begin
            step(ctrl_word((cyc - 1) % 6, opcode));
        end
    endtask

    task automatic run_main(input string tag);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            step(ctrl_word((cyc - 1) % 6, opcode));
            if (cyc == 5)  check({tag, " lda a"}, a_out, 28);
            if (cyc == 11) check({tag, " add a"}, a_out, 42);
            if (cyc == 17) check({tag, " sub a"}, a_out, 37);
            if (cyc == 20) check({tag, " not yet halted"}, halted, 0);
            if (cyc == 21) check({tag, " halted"}, halted, 1);
        end
        check({tag, " carry"}, carry, 1);
        check({tag, " zero"}, zero, 0);
        @(negedge clk);
        ctrl = C_PC_EN;
        #1;
        check({tag, " pc frozen"}, bus, 4);
    endtask

    task automatic load_main();
        logic [7:0] img [16];
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
        img[0] = 8'h0E; img[1] = 8'h1F; img[2] = 8'h2D; img[3] = 8'hF0;
        img[13] = 8'd5; img[14] = 8'd28; img[15] = 8'd14;
        for (int i = 0; i < 16; i++) prog_write(4'(i), img[i]);
    endtask

    // Two-instruction program: LDA 14 then <op> 13.
    task automatic alu_prog(input string name, input logic [3:0] op, input logic [7:0] av,
                            input logic [7:0] bv, input logic [7:0] ea, input logic ec,
                            input logic ez);
        prog_write(4'd0, 8'h0E);
        prog_write(4'd1, {op, 4'hD});
        prog_write(4'd2, 8'hF0);
        prog_write(4'd13, bv);
        prog_write(4'd14, av);
        do_reset();
        run_cycles(12);
        check({name, " a"}, a_out, ea);
        check({name, " carry"}, carry, ec);
        check({name, " zero"}, zero, ez);
    endtask

    typedef struct {
        logic [11:0] c;
        logic [7:0]  exp_bus;
        logic        exp_conflict;
    } bus_vec_t;

    // Reference model state
    int m_pc, m_mar, m_ir, m_a, m_b, m_c, m_z, m_h;
    int m_ram [16];

    function automatic void model_reset();
        m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_h = 0;
    endfunction

    function automatic void model_adder(input logic sub, output int res, output int cy);
        int s;
        if (sub) begin
            s  = m_a - m_b;
            cy = (m_a >= m_b) ? 1 : 0;
        end else begin
            s  = m_a + m_b;
            cy = (s >= 256) ? 1 : 0;
        end
        res = s & 255;
    endfunction

    function automatic void model_bus(input logic [11:0] c, output int b, output int conflict);
        int n, res, cy;
        n = int'(c[7]) + int'(c[0]) + int'(c[3]) + int'(c[5]) + int'(c[9]);
        conflict = (n > 1) ? 1 : 0;
        model_adder(c[1], res, cy);
        if (c[7])      b = m_ram[m_mar];
        else if (c[0]) b = res;
        else if (c[3]) b = m_a;
        else if (c[5]) b = m_ir % 16;
        else if (c[9]) b = m_pc;
        else           b = 0;
    endfunction

    function automatic void model_step(input logic [11:0] c, input int b, input logic we,
                                       input int wa, input int wd);
        int res, cy;
        model_adder(c[1], res, cy);
        if (m_h == 0) begin
            if (c[10]) m_pc = (m_pc + 1) % 16;
            if (c[8])  m_mar = b % 16;
            if (c[6])  m_ir = b;
            if (c[2])  m_b = b;
            if (c[4] && c[0]) begin
                m_c = cy;
                m_z = (res == 0) ? 1 : 0;
            end
            if (c[4])  m_a = b;
            if (c[11]) m_h = 1;
        end
        if (we) m_ram[wa] = wd;
    endfunction

    initial begin
        bus_vec_t vecs [12];
        rst = 1'b1;
        #12;
        check("reset a", a_out, 0);
        check("reset opcode", opcode, 0);
        check("reset carry", carry, 0);
        check("reset zero", zero, 0);
        check("reset halted", halted, 0);
        check("reset bus idle", bus, 0);
        rst = 1'b0;

        // Full program through the controller
        load_main();
        do_reset();
        run_main("prog");

        // Halt freeze; RAM writes still land
        for (int i = 0; i < 10; i++) begin
            step(C_PC_INC | C_A_LD | C_IR_LD | C_B_LD | C_MAR_LD | C_MEM_EN);
        end
        check("halt a hold", a_out, 37);
        check("halt opcode hold", opcode, 4'hF);
        check("halt carry hold", carry, 1);
        check("halt still", halted, 1);
        @(negedge clk);
        ctrl = C_PC_EN;
        #1;
        check("halt pc hold", bus, 4);
        @(negedge clk);
        ctrl = C_MEM_EN;
        prog_we = 1'b1; prog_addr = 4'd3; prog_data = 8'h77;
        #1;
        check("same-edge old data", bus, 8'hF0);
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        check("halt ram write", bus, 8'h77);
        prog_write(4'd3, 8'hF0);

        // Reset mid-instruction (stage 4 of ADD)
        do_reset();
        run_cycles(9);
        check("pre-reset a", a_out, 28);
        @(negedge clk);
        ctrl = ctrl_word(3, opcode);
        #2;
        rst = 1'b1;
        #1;
        check("async rst a", a_out, 0);
        check("async rst opcode", opcode, 0);
        check("async rst halted", halted, 0);
        check("async rst mar/ram", bus, 8'h0E);
        ctrl = C_PC_EN;
        #1;
        check("async rst pc", bus, 0);
        rst = 1'b0;
        run_main("rerun");

        // Arithmetic corners
        alu_prog("sub 3-5", 4'h2, 8'd3, 8'd5, 8'hFE, 1'b0, 1'b0);
        alu_prog("sub 7-7", 4'h2, 8'd7, 8'd7, 8'h00, 1'b1, 1'b1);
        alu_prog("add f0+20", 4'h1, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);

        // PC wrap
        do_reset();
        for (int i = 0; i < 15; i++) step(C_PC_INC);
        @(negedge clk); ctrl = C_PC_EN; #1;
        check("pc at 15", bus, 15);
        step(C_PC_INC);
        @(negedge clk); ctrl = C_PC_EN; #1;
        check("pc wrap", bus, 0);

        // Bus mux table: PC=7, MAR=6, RAM[6]=5B, IR=5B, A=A7, B=5B
        prog_write(4'd5, 8'hA7);
        prog_write(4'd6, 8'h5B);
        do_reset();
        for (int i = 0; i < 5; i++) step(C_PC_INC);
        step(C_PC_EN | C_MAR_LD);
        step(C_MEM_EN | C_A_LD);
        step(C_PC_INC);
        step(C_PC_EN | C_MAR_LD);
        step(C_MEM_EN | C_IR_LD);
        step(C_MEM_EN | C_B_LD);
        step(C_PC_INC);
        check("table opcode", opcode, 4'h5);
        vecs[0]  = '{12'h000, 8'h00, 1'b0};
        vecs[1]  = '{C_PC_EN, 8'h07, 1'b0};
        vecs[2]  = '{C_MEM_EN, 8'h5B, 1'b0};
        vecs[3]  = '{C_IR_EN, 8'h0B, 1'b0};
        vecs[4]  = '{C_A_EN, 8'hA7, 1'b0};
        vecs[5]  = '{C_ADD_EN, 8'h02, 1'b0};
        vecs[6]  = '{C_ADD_EN | C_SUB, 8'h4C, 1'b0};
        vecs[7]  = '{C_MEM_EN | C_A_EN, 8'h5B, 1'b1};
        vecs[8]  = '{C_ADD_EN | C_A_EN, 8'h02, 1'b1};
        vecs[9]  = '{C_A_EN | C_IR_EN | C_PC_EN, 8'hA7, 1'b1};
        vecs[10] = '{C_IR_EN | C_PC_EN, 8'h0B, 1'b1};
        vecs[11] = '{C_MEM_EN | C_ADD_EN | C_A_EN | C_IR_EN | C_PC_EN, 8'h5B, 1'b1};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ctrl = vecs[i].c;
            #1;
            check($sformatf("mux bus %0d", i), bus, vecs[i].exp_bus);
            check($sformatf("mux conflict %0d", i), bus_conflict, vecs[i].exp_conflict);
        end

        // Random ctrl against the reference model
        for (int i = 0; i < 16; i++) begin
            m_ram[i] = int'($urandom_range(0, 255));
            prog_write(4'(i), 8'(m_ram[i]));
        end
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [11:0] c;
            logic        we;
            int          wa, wd, eb, ec;
            if (cyc % 64 == 63) begin
                @(negedge clk);
                ctrl = '0;
                rst  = 1'b1;
                #1;
                model_reset();
                check("rand rst a", a_out, 0);
                check("rand rst halted", halted, 0);
                rst = 1'b0;
            end
            c = 12'($urandom) & 12'h7FF;
            if ($urandom_range(0, 47) == 0) c = c | C_HLT;
            we = ($urandom_range(0, 3) == 0);
            wa = int'($urandom_range(0, 15));
            wd = int'($urandom_range(0, 255));
            @(negedge clk);
            ctrl = c;
            prog_we = we;
            prog_addr = 4'(wa);
            prog_data = 8'(wd);
            #1;
            model_bus(c, eb, ec);
            check("rand bus", bus, eb);
            check("rand conflict", bus_conflict, ec);
            model_step(c, eb, we, wa, wd);
            @(posedge clk);
            #1;
            prog_we = 1'b0;
            check("rand a", a_out, m_a);
            check("rand carry", carry, m_c);
            check("rand zero", zero, m_z);
            check("rand halted", halted, m_h);
            check("rand opcode", opcode, m_ir / 16);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
